// File: rtl/cru_sync_writer.sv
// ---------------------------------------------------------------------------
// cru_sync_writer
//
// Purpose:
//   Captures TI-99/4A CRU single-bit writes into a 4-bit register bank that
//   runs on a local system clock.  CRUCLK and CRUOUT arrive asynchronously,
//   so both are passed through 2-flop synchronisers.  A write is accepted
//   only after the synchronised CRUCLK has been low for FILTER_LEN
//   consecutive clk cycles, and at most once per low period.  A write of 1
//   to bit 3 fires (or retriggers) a PULSE_LEN-cycle rpi_reset pulse.
//
// Ports:
//   clk         in   local system clock, sole clock of the block
//   reset_n     in   asynchronous active-low reset
//   cru_base    in   [3:0]  card CRU base nibble, compared with addr[4:7]
//   ti_cru_clk  in   TI CRUCLK, asynchronous, active-low write strobe
//   addr        in   [0:14] TI address bus (bit 0 = MSB), stable while
//                    ti_cru_clk is low
//   ti_cru_out  in   TI CRUOUT serial data bit
//   ti_cru_in   out  TI CRUIN readback bit
//   bits        out  [0:3] registered CRU bits
//   wr_strobe   out  one-clk pulse marking a bit update
//   wr_index    out  [1:0] index of the most recently written bit
//   rpi_reset   out  stretched reset pulse to the Raspberry Pi
//
// Parameters:
//   FILTER_LEN  cycles of synchronised CRUCLK low before accept (1..15)
//   PULSE_LEN   rpi_reset pulse length in clk cycles (2..255)
//
// Configuration macro:
//   CRU_READBACK_EN  when defined, ti_cru_in returns the addressed bit for a
//                    decoded address; when undefined, ti_cru_in is tied to 0.
// ---------------------------------------------------------------------------
module cru_sync_writer #(
    parameter int unsigned FILTER_LEN = 3,
    parameter int unsigned PULSE_LEN  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  cru_base,
    input  logic        ti_cru_clk,
    input  logic [0:14] addr,
    input  logic        ti_cru_out,
    output logic        ti_cru_in,
    output logic [0:3]  bits,
    output logic        wr_strobe,
    output logic [1:0]  wr_index,
    output logic        rpi_reset
);

    localparam logic [3:0] FILTER_LAST = 4'(FILTER_LEN);
    localparam logic [7:0] PULSE_LOAD  = 8'(PULSE_LEN);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOWCNT = 2'd1,
        ST_ARMED  = 2'd2
    } state_e;

    // -----------------------------------------------------------------------
    // Synchronisers (reset to 1 = strobe inactive)
    // -----------------------------------------------------------------------
    logic cru_clk_meta_q;
    logic cru_clk_sync_q;
    logic cru_out_meta_q;
    logic cru_out_sync_q;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e      state_q,     state_d;
    logic [3:0]  fcnt_q,      fcnt_d;
    logic [0:3]  bits_q,      bits_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [1:0]  wr_index_q,  wr_index_d;
    logic [7:0]  pcnt_q,      pcnt_d;
    logic        rpi_reset_q, rpi_reset_d;

    // -----------------------------------------------------------------------
    // Address decode: select nibble 0001, base nibble match, bit number 0..3.
    // addr is only acted on at the accept edge, where it is guaranteed stable.
    // -----------------------------------------------------------------------
    logic       addr_hit;
    logic [1:0] addr_idx;

    assign addr_idx = addr[13:14];
    assign addr_hit = (addr[0:3] == 4'b0001) &&
                      (addr[4:7] == cru_base) &&
                      (addr[8:12] == 5'd0);

    // accept is high only on the single edge where the low filter completes.
    logic accept;
    logic write_en;

    assign write_en = accept && addr_hit;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave it unassigned; that is what keeps this block latch-free.
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        accept      = 1'b0;
        bits_d      = bits_q;
        wr_strobe_d = 1'b0;
        wr_index_d  = wr_index_q;
        pcnt_d      = pcnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!cru_clk_sync_q) begin
                    fcnt_d = 4'd1;
                    // With a one-cycle filter the first low sample already
                    // completes the filter.
                    if (FILTER_LAST == 4'd1) begin
                        accept  = 1'b1;
                        state_d = ST_ARMED;
                    end else begin
                        state_d = ST_LOWCNT;
                    end
                end
            end

            ST_LOWCNT: begin
                if (cru_clk_sync_q) begin
                    // Glitch or too-short low: drop it without writing.
                    fcnt_d  = 4'd0;
                    state_d = ST_IDLE;
                end else begin
                    fcnt_d = fcnt_q + 4'd1;
                    if (fcnt_d == FILTER_LAST) begin
                        accept  = 1'b1;
                        state_d = ST_ARMED;
                    end
                end
            end

            ST_ARMED: begin
                // Hold here until the strobe returns high so a long low
                // period cannot produce a second write.
                if (cru_clk_sync_q) begin
                    fcnt_d  = 4'd0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                fcnt_d  = 4'd0;
                state_d = ST_IDLE;
            end
        endcase

        if (write_en) begin
            bits_d[addr_idx] = cru_out_sync_q;
            wr_strobe_d      = 1'b1;
            wr_index_d       = addr_idx;
        end

        // Pulse stretcher: a write of 1 to bit 3 (re)loads the full length,
        // including on the last high cycle, so retriggers never leave a gap.
        // A write of 0 to bit 3 leaves a running pulse alone.
        if (write_en && (addr_idx == 2'd3) && cru_out_sync_q) begin
            pcnt_d = PULSE_LOAD;
        end else if (pcnt_q != 8'd0) begin
            pcnt_d = pcnt_q - 8'd1;
        end

        // Registered output: high for exactly the cycles the counter is
        // non-zero, starting the cycle after the load.
        rpi_reset_d = (pcnt_d != 8'd0);
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cru_clk_meta_q <= 1'b1;
            cru_clk_sync_q <= 1'b1;
            cru_out_meta_q <= 1'b1;
            cru_out_sync_q <= 1'b1;
            state_q        <= ST_IDLE;
            fcnt_q         <= 4'd0;
            bits_q         <= 4'b0000;
            wr_strobe_q    <= 1'b0;
            wr_index_q     <= 2'd0;
            pcnt_q         <= 8'd0;
            rpi_reset_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge value of the others, independent of statement order.
            cru_clk_meta_q <= ti_cru_clk;
            cru_clk_sync_q <= cru_clk_meta_q;
            cru_out_meta_q <= ti_cru_out;
            cru_out_sync_q <= cru_out_meta_q;
            state_q        <= state_d;
            fcnt_q         <= fcnt_d;
            bits_q         <= bits_d;
            wr_strobe_q    <= wr_strobe_d;
            wr_index_q     <= wr_index_d;
            pcnt_q         <= pcnt_d;
            rpi_reset_q    <= rpi_reset_d;
        end
    end

    assign bits      = bits_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_index  = wr_index_q;
    assign rpi_reset = rpi_reset_q;

    // -----------------------------------------------------------------------
    // CRU readback
    // -----------------------------------------------------------------------
`ifdef CRU_READBACK_EN
    assign ti_cru_in = addr_hit ? bits_q[addr_idx] : 1'b0;
`else
    assign ti_cru_in = 1'b0;
`endif

endmodule

// File: tb/tb_cru_sync_writer.sv
// ---------------------------------------------------------------------------
// tb_cru_sync_writer
//
// Self-checking bench for cru_sync_writer with default parameters.  Every
// expected write is pushed to a scoreboard when its stimulus is driven and
// popped when the DUT pulses wr_strobe.  Outputs are sampled on the falling
// edge; inputs change 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_cru_sync_writer;

    localparam int FILTER_LEN = 3;
    localparam int PULSE_LEN  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  cru_base = 4'h1;
    logic        ti_cru_clk = 1'b1;
    logic [0:14] addr = '0;
    logic        ti_cru_out = 1'b0;
    logic        ti_cru_in;
    logic [0:3]  bits;
    logic        wr_strobe;
    logic [1:0]  wr_index;
    logic        rpi_reset;

    cru_sync_writer #(
        .FILTER_LEN(FILTER_LEN),
        .PULSE_LEN (PULSE_LEN)
    ) dut (
        .clk       (clk),
        .reset_n   (rst_n),
        .cru_base  (cru_base),
        .ti_cru_clk(ti_cru_clk),
        .addr      (addr),
        .ti_cru_out(ti_cru_out),
        .ti_cru_in (ti_cru_in),
        .bits      (bits),
        .wr_strobe (wr_strobe),
        .wr_index  (wr_index),
        .rpi_reset (rpi_reset)
    );

    always #5 clk = ~clk;

    // Rising-edge counter: after edge N, cyc == N.
    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0] idx;
        logic [0:3] bits;
    } exp_t;

    exp_t       sb_q[$];
    logic [0:3] model_bits = 4'b0000;

    // Strobe / pulse monitor
    int strobe_cnt      = 0;
    int last_strobe_cyc = 0;
    int run             = 0;
    int last_run        = 0;
    int runs_done       = 0;
    int rise_cyc        = 0;

    always @(negedge clk) begin
        if (wr_strobe) begin
            strobe_cnt++;
            last_strobe_cyc = cyc;
            if (sb_q.size() == 0) begin
                check("unexp_strobe", 32'(wr_strobe), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("wr_index", 32'(wr_index), 32'(e.idx));
                check("bits", 32'(bits), 32'(e.bits));
            end
        end
        if (rpi_reset) begin
            if (run == 0) rise_cyc = cyc;
            run++;
        end else if (run != 0) begin
            last_run = run;
            runs_done++;
            run = 0;
        end
    end

    // Address with select nibble 0001, base nibble and 7-bit bit number.
    function automatic logic [0:14] mk_addr(input logic [3:0] base, input logic [6:0] sel);
        return {4'b0001, base, sel};
    endfunction

    // Drive one CRUCLK low period of 'low' rising edges followed by 'tail'
    // high edges (low=5, tail=4 gives accept edges exactly 10 cycles apart).
    task automatic do_write(input logic [0:14] a, input logic d, input int low,
                            input int tail, input bit expect_wr);
        int k;
        int s0;
        addr       = a;
        ti_cru_out = d;
        @(posedge clk); #1;
        ti_cru_clk = 1'b0;
        k  = cyc + 1;          // first edge that samples the low level
        s0 = strobe_cnt;
        if (expect_wr) begin
            model_bits[a[13:14]] = d;
            sb_q.push_back(exp_t'{idx: a[13:14], bits: model_bits});
        end
        repeat (low) @(posedge clk);
        #1 ti_cru_clk = 1'b1;
        repeat (tail) @(posedge clk);
        #1;
        if (expect_wr) begin
            check("strobe_count", 32'(strobe_cnt - s0), 32'd1);
            check("latency", 32'(last_strobe_cyc), 32'(k + 1 + FILTER_LEN));
        end else begin
            check("no_strobe", 32'(strobe_cnt - s0), 32'd0);
        end
    endtask

    initial begin
        int r0;
        int s0;
        int k;

        // ---------------- reset state ----------------
        #2;
        check("rst_bits", 32'(bits), 32'd0);
        check("rst_strobe", 32'(wr_strobe), 32'd0);
        check("rst_index", 32'(wr_index), 32'd0);
        check("rst_rpi", 32'(rpi_reset), 32'd0);
        check("rst_cru_in", 32'(ti_cru_in), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // ---------------- basic write: 1 to bit 2 ----------------
        do_write(mk_addr(4'h1, 7'd2), 1'b1, 10, 4, 1'b1);
        check("w1_bits", 32'(bits), 32'(4'b0010));
        check("w1_index", 32'(wr_index), 32'd2);

        // ---------------- too-short low period ----------------
        do_write(mk_addr(4'h1, 7'd2), 1'b0, 2, 6, 1'b0);
        check("short_bits", 32'(bits), 32'(4'b0010));

        // ---------------- non-matching addresses ----------------
        do_write(15'h0A00, 1'b1, 5, 4, 1'b0);
        do_write(mk_addr(4'h1, 7'd4), 1'b1, 5, 4, 1'b0);
        do_write(mk_addr(4'h3, 7'd1), 1'b1, 5, 4, 1'b0);
        check("nomatch_bits", 32'(bits), 32'(4'b0010));
        check("nomatch_index", 32'(wr_index), 32'd2);

        // ---------------- single rpi_reset pulse ----------------
        r0 = runs_done;
        do_write(mk_addr(4'h1, 7'd3), 1'b1, 5, 4, 1'b1);
        check("pulse_start", 32'(rise_cyc), 32'(last_strobe_cyc));
        repeat (PULSE_LEN + 4) @(posedge clk);
        #1;
        check("pulse_runs", 32'(runs_done - r0), 32'd1);
        check("pulse_len", 32'(last_run), 32'(PULSE_LEN));

        // ---------------- retrigger 10 cycles later ----------------
        r0 = runs_done;
        do_write(mk_addr(4'h1, 7'd3), 1'b1, 5, 4, 1'b1);
        do_write(mk_addr(4'h1, 7'd3), 1'b1, 5, 4, 1'b1);
        repeat (PULSE_LEN + 4) @(posedge clk);
        #1;
        check("retrig_runs", 32'(runs_done - r0), 32'd1);
        check("retrig_len", 32'(last_run), 32'(10 + PULSE_LEN));

        // ---------------- write 0 does not truncate ----------------
        r0 = runs_done;
        do_write(mk_addr(4'h1, 7'd3), 1'b1, 5, 4, 1'b1);
        do_write(mk_addr(4'h1, 7'd3), 1'b0, 5, 4, 1'b1);
        repeat (PULSE_LEN + 4) @(posedge clk);
        #1;
        check("w0_runs", 32'(runs_done - r0), 32'd1);
        check("w0_len", 32'(last_run), 32'(PULSE_LEN));
        check("w0_bits", 32'(bits), 32'(4'b0010));

        // ---------------- readback ----------------
        do_write(mk_addr(4'h1, 7'd0), 1'b1, 5, 4, 1'b1);
        check("rb_bits", 32'(bits), 32'(4'b1010));
        addr = mk_addr(4'h1, 7'd0);
        #1;
`ifdef CRU_READBACK_EN
        check("rb_idx0", 32'(ti_cru_in), 32'd1);
`else
        check("rb_idx0", 32'(ti_cru_in), 32'd0);
`endif
        addr = mk_addr(4'h1, 7'd1);
        #1;
        check("rb_idx1", 32'(ti_cru_in), 32'd0);

        // ---------------- reset mid-pulse ----------------
        do_write(mk_addr(4'h1, 7'd3), 1'b1, 5, 4, 1'b1);
        check("mid_pulse_active", 32'(rpi_reset), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstp_rpi", 32'(rpi_reset), 32'd0);
        check("rstp_bits", 32'(bits), 32'd0);
        check("rstp_index", 32'(wr_index), 32'd0);
        check("rstp_strobe", 32'(wr_strobe), 32'd0);
        model_bits = 4'b0000;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // ---------------- reset mid-filter, short low after release ------
        s0 = strobe_cnt;
        addr       = mk_addr(4'h1, 7'd1);
        ti_cru_out = 1'b1;
        @(posedge clk); #1;
        ti_cru_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 ti_cru_clk = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("rstf_no_strobe", 32'(strobe_cnt - s0), 32'd0);
        check("rstf_bits", 32'(bits), 32'd0);

        // ---------------- reset mid-filter, low continues after release --
        s0 = strobe_cnt;
        @(posedge clk); #1;
        ti_cru_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        k = cyc + 1;
        model_bits[1] = 1'b1;
        sb_q.push_back(exp_t'{idx: 2'd1, bits: model_bits});
        repeat (10) @(posedge clk);
        #1 ti_cru_clk = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rstr_strobe", 32'(strobe_cnt - s0), 32'd1);
        check("rstr_latency", 32'(last_strobe_cyc), 32'(k + 1 + FILTER_LEN));
        check("rstr_bits", 32'(bits), 32'(4'b0100));

        // ---------------- scoreboard drained ----------------
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
